pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter: DATA_W, default 106, width of the datapath payload (two register operands, offset, rd, rt).
REQ-002 Parameter: CTRL_W, default 9, width of the control bundle (ALUsrc, ALUop, RegDst, PCSrc, memRead, memWrite, MemtoReg, RegWrite).
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: in_valid  input  1  upstream presents a valid entry.
REQ-006 Port: in_ready  output  1  stage can accept an entry this cycle.
REQ-007 Port: in_data  input  DATA_W  upstream payload.
REQ-008 Port: in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 Port: flush  input  1  synchronous kill of all held entries.
REQ-010 Port: out_valid  output  1  stage presents a valid entry.
REQ-011 Port: out_ready  input  1  downstream accepts this cycle.
REQ-012 Port: out_data  output  DATA_W  head payload.
REQ-013 Port: out_ctrl  output  CTRL_W  head control, zeroed when out_valid=0.
REQ-014 Port: occupancy  output  2  held entry count: 0, 1 or 2.

Function
REQ-015 Storage SHALL be two entries, main (head) and skid, each with a valid bit; strict FIFO order.
REQ-016 Accept SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-017 in_ready SHALL be registered and equal to ~skid_valid; no combinational path from out_ready to in_ready.
REQ-018 States SHALL be EMPTY (occ 0), ONE (occ 1, main only) and FULL (occ 2).
REQ-019 EMPTY: accept -> ONE, entry loaded to main; no accept -> EMPTY.
REQ-020 ONE: accept & pop -> ONE, main replaced by the new entry; accept only -> FULL, new entry to skid; pop only -> EMPTY; neither -> ONE.
REQ-021 FULL: pop -> ONE, skid moves to main; no pop -> FULL, both held; accept impossible (in_ready=0).
REQ-022 Latency SHALL be 1 cycle: an entry accepted at edge N is on out_* with out_valid=1 after edge N.
REQ-023 Throughput SHALL be one entry per cycle while out_ready=1.
REQ-024 out_valid SHALL equal main valid; out_data and out_ctrl SHALL come from main.
REQ-025 out_ctrl SHALL be all zeros whenever out_valid=0 (bubble never asserts RegWrite/memWrite).
REQ-026 out_data SHALL hold its last value when out_valid=0.
REQ-027 flush SHALL take priority over accept and pop: next state EMPTY, both valid bits cleared, and any entry offered in the flush cycle discarded.
REQ-028 Stalled head (out_valid=1, out_ready=0) SHALL hold out_data/out_ctrl stable until popped or flushed.
REQ-029 occupancy SHALL always equal main_valid + skid_valid.

Reset
REQ-030 On reset assertion, at any time including mid-transfer, all valid bits, out_data, out_ctrl, skid contents and occupancy SHALL go to 0 asynchronously.
REQ-031 in_ready SHALL be 1 while reset is asserted and after release with state EMPTY.
REQ-032 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-033 Streaming: out_ready=1, in_valid=1 with data 1,2,3 on consecutive edges -> out_data 1,2,3 on the following edges, occupancy 1, in_ready stays 1.
REQ-034 Back-pressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB emitted in order, none lost or duplicated.
REQ-035 Bubble zeroing: in_ctrl=9'h1FF, in_valid=0 -> out_valid=0 and out_ctrl=0; one accept -> out_ctrl=9'h1FF for exactly one cycle with out_ready=1.
REQ-036 Flush in FULL with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_ctrl=0, offered entry never appears on the output.
REQ-037 Reset mid-operation: assert reset between edges while FULL -> occupancy, out_valid and out_ctrl go to 0 before the next edge; in_ready=1.
REQ-038 Random valid/ready scoreboard for 10k cycles, parameters DATA_W=8 and CTRL_W=1 plus the defaults -> output sequence equals the accepted sequence, and occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for the skid-buffered pipeline stage.
// The stage itself sits on the slave modport. The producer/consumer side,
// for example a testbench or the neighbouring stages, sits on the master modport.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 106,
    parameter int CTRL_W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with a skid slot.
// The main slot is the head of the queue and drives out_*. The skid slot
// catches one extra entry, so in_ready can be a pure register (~skid_valid)
// with no combinational path from out_ready.
// main_ctrl is forced to zero whenever main is empty, so a bubble never
// carries live control bits.
module pipe_stage_skid #(
    parameter int DATA_W = 106,
    parameter int CTRL_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    pipe_stage_skid_if.slave    bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              main_valid;
    logic              skid_valid;
    logic              ready;
    logic [1:0]        occ;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic accept;
    logic pop;

    // Handshakes are qualified by registered state only.
    assign accept = bus.in_valid & ready;
    assign pop    = main_valid & bus.out_ready;

    // State machine with registered valid/ready/occupancy and storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready      <= 1'b1;
            occ        <= 2'd0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (bus.flush) begin
            // Flush wins over accept and pop. Data is kept, control is cleared.
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready      <= 1'b1;
            occ        <= 2'd0;
            main_ctrl  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data  <= bus.in_data;
                        main_ctrl  <= bus.in_ctrl;
                        main_valid <= 1'b1;
                        occ        <= 2'd1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data <= bus.in_data;
                        main_ctrl <= bus.in_ctrl;
                    end else if (accept) begin
                        skid_data  <= bus.in_data;
                        skid_ctrl  <= bus.in_ctrl;
                        skid_valid <= 1'b1;
                        ready      <= 1'b0;
                        occ        <= 2'd2;
                        state      <= FULL;
                    end else if (pop) begin
                        main_valid <= 1'b0;
                        main_ctrl  <= '0;
                        occ        <= 2'd0;
                        state      <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so the only event is a pop.
                    if (pop) begin
                        main_data  <= skid_data;
                        main_ctrl  <= skid_ctrl;
                        skid_valid <= 1'b0;
                        ready      <= 1'b1;
                        occ        <= 2'd1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    ready      <= 1'b1;
                    occ        <= 2'd0;
                    main_ctrl  <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.occupancy = occ;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid.
// Directed scenarios run on the default-width instance. A randomized
// valid/ready/flush run then drives both the default and the narrow instance,
// each checked against a queue-based reference model.
module tb_pipe_stage_skid;
    localparam int AW  = 106;
    localparam int ACW = 9;
    localparam int BW  = 8;
    localparam int BCW = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(AW), .CTRL_W(ACW)) if_a ();
    pipe_stage_skid_if #(.DATA_W(BW), .CTRL_W(BCW)) if_b ();

    pipe_stage_skid #(.DATA_W(AW), .CTRL_W(ACW)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    pipe_stage_skid #(.DATA_W(BW), .CTRL_W(BCW)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference queues hold {ctrl, data}. The head is what the output must show.
    logic [AW+ACW-1:0] qa[$];
    logic [BW+BCW-1:0] qb[$];
    logic [AW-1:0]     last_a;
    logic [BW-1:0]     last_b;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [AW-1:0] d, input logic [ACW-1:0] c,
                           input logic rdy, input logic fl);
        if_a.in_valid  = v;
        if_a.in_data   = d;
        if_a.in_ctrl   = c;
        if_a.out_ready = rdy;
        if_a.flush     = fl;
    endtask

    task automatic model_check_a();
        logic [AW+ACW-1:0] h;
        check_val("a_valid", if_a.out_valid, qa.size() > 0);
        check_val("a_occ", if_a.occupancy, qa.size());
        check_val("a_occ_le2", if_a.occupancy <= 2'd2, 1);
        check_val("a_ready", if_a.in_ready, qa.size() < 2);
        if (qa.size() > 0) begin
            h = qa[0];
            check_val("a_data", if_a.out_data, h[AW-1:0]);
            check_val("a_ctrl", if_a.out_ctrl, h[AW+ACW-1:AW]);
            last_a = h[AW-1:0];
        end else begin
            check_val("a_data_hold", if_a.out_data, last_a);
            check_val("a_ctrl_zero", if_a.out_ctrl, 0);
        end
    endtask

    task automatic model_check_b();
        logic [BW+BCW-1:0] h;
        check_val("b_valid", if_b.out_valid, qb.size() > 0);
        check_val("b_occ", if_b.occupancy, qb.size());
        check_val("b_occ_le2", if_b.occupancy <= 2'd2, 1);
        check_val("b_ready", if_b.in_ready, qb.size() < 2);
        if (qb.size() > 0) begin
            h = qb[0];
            check_val("b_data", if_b.out_data, h[BW-1:0]);
            check_val("b_ctrl", if_b.out_ctrl, h[BW+BCW-1:BW]);
            last_b = h[BW-1:0];
        end else begin
            check_val("b_data_hold", if_b.out_data, last_b);
            check_val("b_ctrl_zero", if_b.out_ctrl, 0);
        end
    endtask

    // Predict the queue after the next edge from the inputs just driven.
    task automatic model_update_a();
        bit acc;
        bit pp;
        acc = if_a.in_valid && (qa.size() < 2);
        pp  = (qa.size() > 0) && if_a.out_ready;
        if (if_a.flush) qa.delete();
        else begin
            if (pp) void'(qa.pop_front());
            if (acc) qa.push_back({if_a.in_ctrl, if_a.in_data});
        end
    endtask

    task automatic model_update_b();
        bit acc;
        bit pp;
        acc = if_b.in_valid && (qb.size() < 2);
        pp  = (qb.size() > 0) && if_b.out_ready;
        if (if_b.flush) qb.delete();
        else begin
            if (pp) void'(qb.pop_front());
            if (acc) qb.push_back({if_b.in_ctrl, if_b.in_data});
        end
    endtask

    initial begin
        drive_a(1'b0, '0, '0, 1'b0, 1'b0);
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_ctrl = '0;
        if_b.out_ready = 1'b0; if_b.flush = 1'b0;

        // Reset state
        #12;
        check_val("rst_occ", if_a.occupancy, 0);
        check_val("rst_valid", if_a.out_valid, 0);
        check_val("rst_ready", if_a.in_ready, 1);
        check_val("rst_ctrl", if_a.out_ctrl, 0);
        check_val("rst_data", if_a.out_data, 0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming 1,2,3
        for (int i = 1; i <= 3; i++) begin
            drive_a(1'b1, AW'(i), ACW'(i), 1'b1, 1'b0);
            @(negedge clk);
            check_val("stream_data", if_a.out_data, i);
            check_val("stream_valid", if_a.out_valid, 1);
            check_val("stream_occ", if_a.occupancy, 1);
            check_val("stream_ready", if_a.in_ready, 1);
        end
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("stream_drain", if_a.out_valid, 0);
        check_val("stream_hold", if_a.out_data, 3);

        // Back-pressure
        drive_a(1'b1, AW'('hA), ACW'(3), 1'b0, 1'b0);
        @(negedge clk);
        check_val("bp_occ1", if_a.occupancy, 1);
        drive_a(1'b1, AW'('hB), ACW'(4), 1'b0, 1'b0);
        @(negedge clk);
        check_val("bp_occ2", if_a.occupancy, 2);
        check_val("bp_ready", if_a.in_ready, 0);
        check_val("bp_head", if_a.out_data, 'hA);
        drive_a(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("bp_stall_data", if_a.out_data, 'hA);
        check_val("bp_stall_ctrl", if_a.out_ctrl, 3);
        if_a.out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_second", if_a.out_data, 'hB);
        check_val("bp_second_ctrl", if_a.out_ctrl, 4);
        check_val("bp_occ_after", if_a.occupancy, 1);
        @(negedge clk);
        check_val("bp_empty", if_a.out_valid, 0);
        check_val("bp_empty_occ", if_a.occupancy, 0);

        // Bubble zeroing
        drive_a(1'b0, AW'('h55), ACW'('h1FF), 1'b1, 1'b0);
        @(negedge clk);
        check_val("bub_valid", if_a.out_valid, 0);
        check_val("bub_ctrl", if_a.out_ctrl, 0);
        if_a.in_valid = 1'b1;
        @(negedge clk);
        check_val("bub_ctrl_live", if_a.out_ctrl, 'h1FF);
        if_a.in_valid = 1'b0;
        @(negedge clk);
        check_val("bub_ctrl_once", if_a.out_ctrl, 0);

        // Flush while FULL with an offer pending
        drive_a(1'b1, AW'('h11), ACW'(1), 1'b0, 1'b0);
        @(negedge clk);
        drive_a(1'b1, AW'('h22), ACW'(2), 1'b0, 1'b0);
        @(negedge clk);
        check_val("fl_full", if_a.occupancy, 2);
        drive_a(1'b1, AW'('h77), ACW'('h1FF), 1'b1, 1'b1);
        @(negedge clk);
        check_val("fl_occ", if_a.occupancy, 0);
        check_val("fl_valid", if_a.out_valid, 0);
        check_val("fl_ctrl", if_a.out_ctrl, 0);
        check_val("fl_ready", if_a.in_ready, 1);
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("fl_no_ghost", if_a.out_valid, 0);

        // Asynchronous reset while FULL
        drive_a(1'b1, AW'('h33), ACW'(5), 1'b0, 1'b0);
        @(negedge clk);
        drive_a(1'b1, AW'('h44), ACW'(6), 1'b0, 1'b0);
        @(negedge clk);
        check_val("ar_full", if_a.occupancy, 2);
        #2 reset = 1'b1;
        #1;
        check_val("ar_occ", if_a.occupancy, 0);
        check_val("ar_valid", if_a.out_valid, 0);
        check_val("ar_ctrl", if_a.out_ctrl, 0);
        check_val("ar_data", if_a.out_data, 0);
        check_val("ar_ready", if_a.in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        drive_a(1'b1, AW'('h5), ACW'(7), 1'b0, 1'b0);
        @(negedge clk);
        check_val("ar_first_accept", if_a.out_valid, 1);
        check_val("ar_first_data", if_a.out_data, 5);

        // Randomized scoreboard run on both widths
        drive_a(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        qa.delete(); qb.delete();
        last_a = '0; last_b = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            model_check_a();
            model_check_b();
            drive_a($urandom_range(0, 3) != 0,
                    AW'({$urandom, $urandom, $urandom, $urandom}),
                    ACW'($urandom),
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 63) == 0);
            if_b.in_valid  = $urandom_range(0, 3) != 0;
            if_b.in_data   = BW'($urandom);
            if_b.in_ctrl   = BCW'($urandom);
            if_b.out_ready = $urandom_range(0, 2) != 0;
            if_b.flush     = $urandom_range(0, 63) == 0;
            model_update_a();
            model_update_b();
        end
        @(negedge clk);
        model_check_a();
        model_check_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
